// File: rtl/coherence_control.sv
// Two-CPU snooping coherence controller: arbitrates instruction fetches,
// data writebacks and coherent data reads onto a single RAM port, snooping
// the other CPU on every data read.
// Optional feature macro: COHERENCE_C2C_EN. When it is defined, Modified
// data returned by a snooped CPU is forwarded straight to the requester.
// When it is undefined, that data is written back and then re-read from RAM.

package coherence_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module coherence_control
  import coherence_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  input  logic [CPUS-1:0]              ccwrite,
  input  logic [CPUS-1:0]              cctrans,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [CPUS-1:0]              ccwait,
  output logic [CPUS-1:0]              ccinv,
  output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DWRITE = 3'd2,
    SNOOP  = 3'd3,
    C2C    = 3'd4,
    DLOAD  = 3'd5
  } state_t;

  state_t r_state;
  logic   r_req;   // CPU currently being served
  logic   r_rr;    // CPU favoured when both request the same class

  state_t w_state_nx;
  logic   w_req_nx;
  logic   w_rr_nx;
  logic   w_oth;
  logic   w_access;

  assign w_oth    = ~r_req;
  assign w_access = (ramstate == ACCESS);

  // Single winner from a two-bit request vector; ties go to the pointer.
  function automatic logic pick(input logic [1:0] req, input logic rr);
    if (req == 2'b11) pick = rr;
    else              pick = req[1];
  endfunction

  // State, served CPU and round-robin pointer; reset abandons any transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_req   <= w_req_nx;
      r_rr    <= w_rr_nx;
    end
  end

  // Next-state selection and output decode from the current state.
  always_comb begin
    w_state_nx  = r_state;
    w_req_nx    = r_req;
    w_rr_nx     = r_rr;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      IDLE: begin
        if (|dWEN) begin
          w_req_nx   = pick(dWEN, r_rr);
          w_state_nx = DWRITE;
        end else if (|dREN) begin
          w_req_nx   = pick(dREN, r_rr);
          w_state_nx = SNOOP;
        end else if (|iREN) begin
          w_req_nx   = pick(iREN, r_rr);
          w_state_nx = IFETCH;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_req];
        if (!iREN[r_req]) begin
          w_state_nx = IDLE;
        end else if (w_access) begin
          iwait[r_req] = 1'b0;
          iload[r_req] = ramload;
          w_state_nx   = IDLE;
          w_rr_nx      = w_oth;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_req];
        ramstore = dstore[r_req];
        if (!dWEN[r_req]) begin
          w_state_nx = IDLE;
        end else if (w_access) begin
          dwait[r_req] = 1'b0;
          w_state_nx   = IDLE;
          w_rr_nx      = w_oth;
        end
      end
      SNOOP: begin
        ccwait[w_oth]      = 1'b1;
        ccinv[w_oth]       = ccwrite[r_req];
        ccsnoopaddr[w_oth] = daddr[r_req];
        if (!dREN[r_req])         w_state_nx = IDLE;
        else if (cctrans[w_oth])  w_state_nx = C2C;
        else                      w_state_nx = DLOAD;
      end
      C2C: begin
        // The snooped CPU stays stalled while its Modified line is written back.
        ccwait[w_oth] = 1'b1;
        ramWEN        = 1'b1;
        ramaddr       = daddr[r_req];
        ramstore      = dstore[w_oth];
        if (!dREN[r_req]) begin
          w_state_nx = IDLE;
        end else if (w_access) begin
`ifdef COHERENCE_C2C_EN
          dwait[r_req] = 1'b0;
          dload[r_req] = dstore[w_oth];
          w_state_nx   = IDLE;
          w_rr_nx      = w_oth;
`else
          w_state_nx   = DLOAD;
`endif
        end
      end
      DLOAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_req];
        if (!dREN[r_req]) begin
          w_state_nx = IDLE;
        end else if (w_access) begin
          dwait[r_req] = 1'b0;
          dload[r_req] = ramload;
          w_state_nx   = IDLE;
          w_rr_nx      = w_oth;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/coherence_control.md
COHERENCE_CONTROL -- requirements
Module: coherence_control

Interface
REQ-001 Parameter CPUS, default 2, number of cached processors; only CPUS=2 is supported.
REQ-002 Parameter WORD_W, default 32, width of word_t.
REQ-003 Port CLK, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port nRST, input, 1, reset; asynchronous and active-low.
REQ-005 Ports iREN, dREN, dWEN, input, [CPUS], per-CPU instruction read, data read and data write requests.
REQ-006 Ports iaddr, daddr, dstore, input, [CPUS] x WORD_W, per-CPU fetch address, data address and store data.
REQ-007 Ports ccwrite, cctrans, input, [CPUS]: requester intent is read-exclusive (ccwrite=1) or read-shared (ccwrite=0); while a CPU is snooped, cctrans=1 means it holds the line Modified and dstore carries the line's data.
REQ-008 Ports iwait, dwait, output, [CPUS], per-CPU stall; low for exactly one cycle on completion.
REQ-009 Ports iload, dload, output, [CPUS] x WORD_W, returned data, valid when the matching wait is low.
REQ-010 Ports ccwait, ccinv, output, [CPUS], snoop request and invalidate to the snooped CPU.
REQ-011 Port ccsnoopaddr, output, [CPUS] x WORD_W, the snoop address.
REQ-012 Ports ramREN, ramWEN, output, 1, RAM read and write strobes.
REQ-013 Ports ramaddr, ramstore, output, WORD_W, RAM address and write data.
REQ-014 Port ramload, input, WORD_W, RAM read data.
REQ-015 Port ramstate, input, ramstate_t (FREE/BUSY/ACCESS/ERROR); a RAM access completes only in a cycle with ramstate==ACCESS.

Function
REQ-016 FSM states: IDLE, IFETCH, DWRITE, SNOOP, C2C, DLOAD.
REQ-017 IDLE arbitration priority: any dWEN, then dREN, then iREN.
REQ-018 Arbitration ties across CPUs resolve round-robin; pointer toggles to the other CPU after every completed grant.
REQ-019 Any request is granted on the edge following its assertion; IDLE drives no RAM strobe.
REQ-020 IFETCH: ramREN=1, ramaddr=iaddr[r]; on ACCESS: iwait[r]=0, iload[r]=ramload, next IDLE.
REQ-021 DWRITE (writeback): ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]; on ACCESS: dwait[r]=0, next IDLE; no snoop is issued.
REQ-022 A dREN grant enters SNOOP for exactly one cycle: ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=ccwrite[r], where o is the other CPU.
REQ-023 At the end of SNOOP the FSM samples cctrans[o]: 1 -> C2C, 0 -> DLOAD.
REQ-024 C2C: ccwait[o] held at 1; ramWEN=1, ramaddr=daddr[r], ramstore=dstore[o]; on ACCESS: dwait[r]=0, dload[r]=dstore[o], next IDLE.
REQ-025 DLOAD: ramREN=1, ramaddr=daddr[r]; on ACCESS: dwait[r]=0, dload[r]=ramload, next IDLE.
REQ-026 ramstate ERROR or BUSY: stay in the state with strobes held (retry).
REQ-027 Requester drops its request before ACCESS: abort to IDLE next edge with no wait pulse.
REQ-028 ramREN and ramWEN are never both 1.
REQ-029 A snooped CPU's own requests are not granted while its ccwait=1.
REQ-030 All outputs are registered-state decodes; unused lanes drive wait=1, load=0.

Reset
REQ-031 nRST low asynchronously forces state IDLE and round-robin pointer 0.
REQ-032 During reset: all iwait/dwait=1; ccwait, ccinv, ramREN, ramWEN=0; ccsnoopaddr, ramaddr, ramstore, iload, dload=0.
REQ-033 Reset asserted mid-transaction abandons it; no wait pulse is generated.

Configuration
REQ-034 Macro COHERENCE_C2C_EN defined: C2C forwarding per REQ-024.
REQ-035 Macro COHERENCE_C2C_EN undefined: cctrans[o]=1 performs the C2C RAM write without asserting dwait[r]=0, then enters DLOAD; the requester receives ramload after a second access.

Verification
REQ-036 Reset, then CPU0 iREN, iaddr=0x100, ramload=0xDEAD, ACCESS after 2 BUSY cycles -> iwait[0] low one cycle with iload[0]=0xDEAD; all other waits remain 1.
REQ-037 CPU0 dREN and CPU1 iREN asserted in the same cycle -> CPU0 data is granted first; then CPU1 fetch is granted.
REQ-038 CPU1 dREN, ccwrite=1, daddr=0x200, with CPU0 returning cctrans=1, dstore=0xBEEF -> ccinv[0]=1 and ccsnoopaddr[0]=0x200; RAM is written 0xBEEF at 0x200; dload[1]=0xBEEF (C2C_EN defined).
REQ-039 Repeat REQ-038 with COHERENCE_C2C_EN undefined -> RAM write, then RAM read of 0x200; dwait[1] falls only after the read completes.
REQ-040 Both CPUs issue dWEN in the same cycle; first is ERROR for 3 cycles -> CPU0 write retried until ACCESS; then CPU1 write is serviced; ramREN never asserted.
REQ-041 nRST pulsed during DLOAD -> all outputs take reset values immediately; FSM is IDLE after release.
